mult_div_unit: RTL and testbench

Iterative signed multiply/divide unit downstream of the multicycle control FSM. It is launched by the control's MultStart/DivStart pulses and produces a 64-bit result split into Hi/Lo. The control's DivMult select and RegHighW/RegLowW strobes latch that result into the architectural HI/LO registers. The block reports Busy/Done so the control can wait-state, and DivZero so the exception path can trap.

---
 rtl/cpu_pkg.sv | 7 +
 rtl/mult_div_unit_div_core.sv | 39 +++
 rtl/mult_div_unit.sv | 113 +++++++++++
 tb/tb_mult_div_unit.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings and defaults for the multiply/divide unit
package cpu_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 6;
    typedef enum logic [2:0] {S_IDLE, S_MULT, S_DIV, S_FIX, S_DONE} state_t;
    typedef enum logic {OP_MULT, OP_DIV} op_t;
endpackage

// File: rtl/mult_div_unit_div_core.sv
// div_core: restoring unsigned divider, one quotient bit per enabled step
module div_core
    import cpu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem
);
    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   shifted;
    logic             ge;
    // trial subtraction of the divisor from the partial remainder with the next dividend bit
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        ge      = shifted >= {1'b0, dvs};
    end
    // quotient register doubles as the dividend shifter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo <= '0;
            rem <= '0;
            dvs <= '0;
        end else if (load) begin
            quo <= dividend;
            rem <= '0;
            dvs <= divisor;
        end else if (step) begin
            quo <= {quo[WIDTH-2:0], ge};
            rem <= ge ? WIDTH'(shifted - {1'b0, dvs}) : shifted[WIDTH-1:0];
        end
    end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed Booth multiplier and restoring divider producing Hi/Lo
module mult_div_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             MultStart,
    input  logic             DivStart,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero
);
    state_t             state, next_state;
    op_t                op;
    logic [CNT_W-1:0]   cnt;
    logic               a_neg, b_neg, zero_hit;
    logic [2*WIDTH+1:0] acc;
    logic [WIDTH-1:0]   mcand, a_mag, b_mag, quo, rem;
    logic [WIDTH:0]     booth_hi;
    logic               idle_like, take_mult, take_div, take_zero, last;
    // start arbitration and the Booth add/subtract on a guard-extended upper half
    always_comb begin
        idle_like = state == S_IDLE || state == S_DONE;
        take_mult = idle_like && MultStart;
        take_div  = idle_like && !MultStart && DivStart && B != '0;
        take_zero = idle_like && !MultStart && DivStart && B == '0;
        last      = cnt == CNT_W'(WIDTH - 1);
        a_mag     = A[WIDTH-1] ? -A : A;
        b_mag     = B[WIDTH-1] ? -B : B;
        booth_hi  = acc[2*WIDTH+1:WIDTH+1] +
                    (acc[1:0] == 2'b01 ? {mcand[WIDTH-1], mcand} :
                     acc[1:0] == 2'b10 ? -{mcand[WIDTH-1], mcand} : '0);
    end
    div_core #(.WIDTH(WIDTH)) u_div (
        .clk(Clock),
        .rst_n(Reset),
        .load(take_div),
        .step(state == S_DIV),
        .dividend(a_mag),
        .divisor(b_mag),
        .quo(quo),
        .rem(rem)
    );
    // state register
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state <= S_IDLE;
        else state <= next_state;
    end
    // next-state: iterate WIDTH steps, one fix-up cycle, then a single done cycle
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_DONE: next_state = take_mult ? S_MULT : take_div ? S_DIV :
                                         take_zero ? S_DONE : S_IDLE;
            S_MULT:         next_state = last ? S_FIX : S_MULT;
            S_DIV:          next_state = last ? S_FIX : S_DIV;
            S_FIX:          next_state = S_DONE;
            default:        next_state = S_IDLE;
        endcase
    end
    // status outputs decoded from the state
    always_comb begin
        Busy    = state == S_MULT || state == S_DIV || state == S_FIX;
        Done    = state == S_DONE;
        DivZero = Done && zero_hit;
    end
    // operand capture, Booth shift and result fix-up; Hi/Lo only move in FIX
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cnt      <= '0;
            op       <= OP_MULT;
            a_neg    <= 1'b0;
            b_neg    <= 1'b0;
            zero_hit <= 1'b0;
            acc      <= '0;
            mcand    <= '0;
            Hi       <= '0;
            Lo       <= '0;
        end else begin
            zero_hit <= take_zero;
            if (take_mult) begin
                cnt   <= '0;
                op    <= OP_MULT;
                acc   <= {{(WIDTH+1){1'b0}}, B, 1'b0};
                mcand <= A;
            end else if (take_div) begin
                cnt   <= '0;
                op    <= OP_DIV;
                a_neg <= A[WIDTH-1];
                b_neg <= B[WIDTH-1];
            end else if (state == S_MULT) begin
                cnt <= cnt + 1'b1;
                acc <= {booth_hi[WIDTH], booth_hi, acc[WIDTH:1]};
            end else if (state == S_DIV) begin
                cnt <= cnt + 1'b1;
            end else if (state == S_FIX) begin
                if (op == OP_MULT) begin
                    {Hi, Lo} <= acc[2*WIDTH:1];
                end else begin
                    Lo <= (a_neg ^ b_neg) ? -quo : quo;
                    Hi <= a_neg ? -rem : rem;
                end
            end
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vectors checked against an arithmetic reference model
module tb_mult_div_unit;
    logic        Clock = 1'b0, Reset = 1'b1, MultStart = 1'b0, DivStart = 1'b0;
    logic [31:0] A = '0, B = '0;
    logic [31:0] Hi, Lo;
    logic        Busy, Done, DivZero;
    int          total = 0, passed = 0;
    bit          cmp_on = 1'b0;

    always #5 Clock = ~Clock;

    mult_div_unit dut (
        .Clock(Clock), .Reset(Reset), .MultStart(MultStart), .DivStart(DivStart),
        .A(A), .B(B), .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done), .DivZero(DivZero)
    );

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // signed reference: {hi,lo} = product, or {remainder, quotient} truncated toward zero
    function automatic logic [63:0] ref_op(input bit is_mult, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (is_mult) return 64'(sa * sb);
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // model: 33 busy cycles then a done cycle that publishes the pending result
    int          left_m;
    logic [31:0] hi_m, lo_m, ph, pl;
    logic        done_m, dz_m;
    always @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            left_m <= 0;
            hi_m   <= '0;
            lo_m   <= '0;
            ph     <= '0;
            pl     <= '0;
            done_m <= 1'b0;
            dz_m   <= 1'b0;
        end else begin
            done_m <= left_m == 1;
            dz_m   <= 1'b0;
            if (left_m == 1) begin
                hi_m <= ph;
                lo_m <= pl;
            end
            if (left_m > 0) left_m <= left_m - 1;
            else if (MultStart) begin
                left_m   <= 33;
                {ph, pl} <= ref_op(1'b1, A, B);
            end else if (DivStart && B == '0) begin
                done_m <= 1'b1;
                dz_m   <= 1'b1;
            end else if (DivStart) begin
                left_m   <= 33;
                {ph, pl} <= ref_op(1'b0, A, B);
            end
        end
    end

    always @(negedge Clock)
        if (cmp_on) chk("cycle {busy,done,dz,hi,lo}", {Busy, Done, DivZero, Hi, Lo},
                        {left_m > 0, done_m, dz_m, hi_m, lo_m});

    task automatic launch(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
        MultStart = m;
        DivStart  = d;
        A = a;
        B = b;
        @(posedge Clock);
        #2;
        MultStart = 1'b0;
        DivStart  = 1'b0;
        A = $urandom;
        B = $urandom;
    endtask

    task automatic run(input string nm, input bit m, input bit d, input logic [31:0] a,
                       input logic [31:0] b, input int exp_lat, input int exp_busy, input int poke);
        int busy_n = 0;
        int lat = 0;
        launch(m, d, a, b);
        for (int n = 1; n <= 100; n++) begin
            @(negedge Clock);
            if (n == poke) begin
                MultStart = 1'b1;
                DivStart  = 1'b1;
                A = 32'd100;
                B = 32'd7;
            end else if (n == poke + 1) begin
                MultStart = 1'b0;
                DivStart  = 1'b0;
            end
            if (Done) begin
                lat = n;
                break;
            end
            if (Busy) busy_n++;
        end
        chk({nm, " latency"}, 96'(lat), 96'(exp_lat));
        chk({nm, " busy cycles"}, 96'(busy_n), 96'(exp_busy));
    endtask

    typedef struct {bit m; logic [31:0] a; logic [31:0] b;} vec_t;
    vec_t vecs[7] = '{
        '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF},
        '{1'b1, 32'd123456789, 32'hC521974F},
        '{1'b0, 32'd100, 32'd7},
        '{1'b0, 32'hFFFFFF9C, 32'hFFFFFFF9},
        '{1'b0, 32'd1, 32'h7FFFFFFF},
        '{1'b0, 32'h7FFFFFFF, 32'h80000000},
        '{1'b1, 32'h7FFFFFFF, 32'h80000000}
    };

    initial begin
        int done_n = 0;
        #1 Reset = 1'b0;
        #20;
        chk("reset state", {Busy, Done, DivZero, Hi, Lo}, '0);
        @(negedge Clock);
        Reset  = 1'b1;
        cmp_on = 1'b1;
        @(negedge Clock);

        run("mul 7*-3", 1, 0, 32'd7, 32'hFFFFFFFD, 34, 33, -5);
        chk("mul 7*-3 hi", Hi, 32'hFFFFFFFF);
        chk("mul 7*-3 lo", Lo, 32'hFFFFFFEB);

        run("mul min*min", 1, 0, 32'h80000000, 32'h80000000, 34, 33, -5);
        chk("mul min*min {hi,lo}", {Hi, Lo}, 64'h40000000_00000000);

        run("div -7/2", 0, 1, 32'hFFFFFFF9, 32'd2, 34, 33, -5);
        chk("div -7/2 {dz,hi,lo}", {DivZero, Hi, Lo}, {1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD});

        run("div 7/-2", 0, 1, 32'd7, 32'hFFFFFFFE, 34, 33, -5);
        chk("div 7/-2 {dz,hi,lo}", {DivZero, Hi, Lo}, {1'b0, 32'h00000001, 32'hFFFFFFFD});

        run("div 5/0", 0, 1, 32'd5, 32'd0, 1, 0, -5);
        chk("div 5/0 {dz,hi,lo}", {DivZero, Hi, Lo}, {1'b1, 32'h00000001, 32'hFFFFFFFD});

        run("div min/-1", 0, 1, 32'h80000000, 32'hFFFFFFFF, 34, 33, -5);
        chk("div min/-1 {hi,lo}", {Hi, Lo}, 64'h00000000_80000000);

        run("both starts", 1, 1, 32'd6, 32'd5, 34, 33, -5);
        chk("both starts {hi,lo}", {Hi, Lo}, 64'd30);

        run("start while busy", 1, 0, 32'd3, 32'd4, 34, 33, 5);
        chk("start while busy {hi,lo}", {Hi, Lo}, 64'd12);

        foreach (vecs[i]) run($sformatf("vec %0d", i), vecs[i].m, !vecs[i].m, vecs[i].a, vecs[i].b, 34, 33, -5);

        launch(1, 0, 32'd9, 32'd9);
        repeat (10) @(negedge Clock);
        #1 Reset = 1'b0;
        #1 chk("reset mid-op", {Busy, Done, DivZero, Hi, Lo}, '0);
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge Clock);
            if (Done) done_n++;
        end
        chk("no done after reset", 96'(done_n), 96'd0);
        run("mul 9*9", 1, 0, 32'd9, 32'd9, 34, 33, -5);
        chk("mul 9*9 {hi,lo}", {Hi, Lo}, 64'd81);

        cmp_on = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
